// File: rtl/key_event_detector_pkg.sv
// key_event_detector_pkg
//   Shared definitions for the key event detector: FSM state encodings and
//   the default long-press / auto-repeat cycle counts, also used by the menu
//   FSM so both agree on timing.
package key_event_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHORT = 2'd1,
    ST_LONG  = 2'd2
  } state_t;

  localparam int unsigned LONG_CYCLES_DEF   = 100_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 20_000_000;

endpackage

// File: rtl/key_event_detector_if.sv
// key_event_detector_if
//   Event bundle produced by one key_event_detector.
//   press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse:
//     single-cycle event pulses
//   held: level, high while a press is being tracked
//   master: the detector (drives everything); slave: the consuming FSM.
interface key_event_detector_if;

  logic press_pulse;
  logic release_pulse;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  modport master (
    output press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held
  );

  modport slave (
    input press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held
  );

endinterface

// File: rtl/key_edge_sync.sv
// key_edge_sync
//   Two-stage register on the debounced key level plus rise/fall decode.
//   Ports: clk, rst_n (sync, active-low), key_in (1 = pressed),
//          rise / fall (combinational from the registered pair).
//   Both stages reset to 1 so a key already held through reset looks like
//   a steady level, not a press.
module key_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic rise,
  output logic fall
);

  logic key_s;
  logic key_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_s <= 1'b1;
      key_q <= 1'b1;
    end else begin
      key_s <= key_in;
      key_q <= key_s;
    end
  end

  assign rise = key_s & ~key_q;
  assign fall = ~key_s & key_q;

endmodule

// File: rtl/key_event_detector.sv
// key_event_detector
//   Turns a debounced key level into press / release / short / long event
//   pulses, with optional auto-repeat while the key stays held long.
//   Ports: clk, rst_n (sync, active-low), key_in (1 = pressed),
//          ev (key_event_detector_if.master): event pulses and held level.
//   Parameters: LONG_CYCLES   hold length that counts as a long press (>=2)
//               REPEAT_CYCLES auto-repeat period once long (>=2, <=LONG_CYCLES)
//   Build option: define KEY_REPEAT_EN to enable repeat_pulse; without it
//   repeat_pulse is tied low and the counter simply holds in LONG.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | key released, waiting for a rising edge
//   ST_SHORT | key held, long threshold not yet reached
//   ST_LONG  | key held past the long threshold (repeat period runs)
module key_event_detector
  import key_event_detector_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_in,
  key_event_detector_if.master  ev
);

  localparam int CW = $clog2(LONG_CYCLES);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

  logic rise;
  logic fall;

  key_edge_sync u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_in (key_in),
    .rise   (rise),
    .fall   (fall)
  );

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
`ifdef KEY_REPEAT_EN
  logic          rep_q, rep_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      short_q <= short_d;
      long_q  <= long_d;
`ifdef KEY_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_SHORT;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      ST_SHORT: begin
        // Release takes priority over reaching the long threshold.
        if (fall) begin
          state_d = ST_IDLE;
          rel_d   = 1'b1;
          short_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LONG: begin
        if (fall) begin
          state_d = ST_IDLE;
          rel_d   = 1'b1;
        end
`ifdef KEY_REPEAT_EN
        else if (cnt_q == REP_LAST) begin
          cnt_d = '0;
          rep_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign ev.press_pulse   = press_q;
  assign ev.release_pulse = rel_q;
  assign ev.short_pulse   = short_q;
  assign ev.long_pulse    = long_q;
`ifdef KEY_REPEAT_EN
  assign ev.repeat_pulse  = rep_q;
`else
  assign ev.repeat_pulse  = 1'b0;
`endif
  assign ev.held          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_key_event_detector.sv
// tb_key_event_detector
//   Drives key_event_detector with directed scenarios and random key
//   traffic, checking every cycle against a press-age reference model.
module tb_key_event_detector;

  localparam int LC = 8;
  localparam int RC = 4;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_in = 1'b0;

  always #5 clk = ~clk;

  key_event_detector_if ev();

  key_event_detector #(
    .LONG_CYCLES   (LC),
    .REPEAT_CYCLES (RC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_in (key_in),
    .ev     (ev)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // reference model: key samples from the last two edges plus press age
  bit m_h1, m_h0;
  bit m_pressed, m_long_done;
  int m_age;
  bit e_press, e_rel, e_short, e_long, e_rep;

  // per-scenario tallies of observed DUT pulses
  int t_press, t_rel, t_short, t_long, t_rep, t_held;
  int press_at, long_at;
  int rep_at[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    e_press = 0; e_rel = 0; e_short = 0; e_long = 0; e_rep = 0;
    if (!rst_n) begin
      m_h1 = 1; m_h0 = 1;
      m_pressed = 0; m_long_done = 0; m_age = 0;
    end else begin
      if (!m_pressed) begin
        if (m_h1 && !m_h0) begin
          m_pressed = 1; m_long_done = 0; m_age = 0; e_press = 1;
        end
      end else if (!m_h1 && m_h0) begin
        m_pressed = 0;
        e_rel = 1;
        e_short = !m_long_done;
      end else begin
        m_age++;
        if (m_age == LC) begin
          e_long = 1;
          m_long_done = 1;
        end else if (REP_EN && m_age > LC && ((m_age - LC) % RC) == 0) begin
          e_rep = 1;
        end
      end
      m_h0 = m_h1;
      m_h1 = key_in;
    end
  endtask

  task automatic clr_tally();
    t_press = 0; t_rel = 0; t_short = 0; t_long = 0; t_rep = 0; t_held = 0;
    press_at = -100; long_at = -100;
    rep_at.delete();
  endtask

  task automatic step(input bit k, input bit r);
    key_in = k;
    rst_n = r;
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    chk("press",   ev.press_pulse,   e_press);
    chk("release", ev.release_pulse, e_rel);
    chk("short",   ev.short_pulse,   e_short);
    chk("long",    ev.long_pulse,    e_long);
    chk("repeat",  ev.repeat_pulse,  e_rep);
    chk("held",    ev.held,          m_pressed);
    if (ev.press_pulse === 1'b1) begin t_press++; press_at = cyc; end
    if (ev.release_pulse === 1'b1) t_rel++;
    if (ev.short_pulse === 1'b1) t_short++;
    if (ev.long_pulse === 1'b1) begin t_long++; long_at = cyc; end
    if (ev.repeat_pulse === 1'b1) begin t_rep++; rep_at.push_back(cyc); end
    if (ev.held === 1'b1) t_held++;
  endtask

  task automatic run(input bit k, input int n);
    for (int i = 0; i < n; i++) step(k, 1'b1);
  endtask

  initial begin
    clr_tally();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    run(1'b0, 3);

    // 1: short press
    clr_tally();
    run(1'b1, 3);
    run(1'b0, 6);
    chk("s1_press_cnt", t_press, 1);
    chk("s1_rel_cnt", t_rel, 1);
    chk("s1_short_cnt", t_short, 1);
    chk("s1_long_cnt", t_long, 0);
    chk("s1_held_len", (t_held >= 3 && t_held <= 4), 1);

    // 2: long hold
    clr_tally();
    run(1'b1, 20);
    run(1'b0, 6);
    chk("s2_press_cnt", t_press, 1);
    chk("s2_long_cnt", t_long, 1);
    chk("s2_long_delay", long_at - press_at, LC);
    chk("s2_rel_cnt", t_rel, 1);
    chk("s2_short_cnt", t_short, 0);
`ifdef KEY_REPEAT_EN
    chk("s2_rep_cnt", t_rep, 2);
    chk("s2_rep0_delay", (rep_at.size() > 0) ? rep_at[0] - long_at : -1, RC);
    chk("s2_rep1_delay", (rep_at.size() > 1) ? rep_at[1] - long_at : -1, 2 * RC);
`else
    chk("s2_rep_cnt", t_rep, 0);
`endif

    // 3: release coinciding with the long threshold
    clr_tally();
    run(1'b1, LC);
    run(1'b0, 6);
    chk("s3_short_cnt", t_short, 1);
    chk("s3_long_cnt", t_long, 0);
    chk("s3_rel_cnt", t_rel, 1);

    // 4: key held through reset
    clr_tally();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    run(1'b1, 5);
    run(1'b0, 5);
    chk("s4_press_cnt", t_press, 0);
    chk("s4_rel_cnt", t_rel, 0);
    clr_tally();
    run(1'b1, 3);
    run(1'b0, 6);
    chk("s4_next_press", t_press, 1);
    chk("s4_next_short", t_short, 1);

    // 5: reset while in LONG
    clr_tally();
    run(1'b1, 12);
    step(1'b1, 1'b0);
    chk("s5_held_after_rst", ev.held, 1'b0);
    run(1'b1, 3);
    run(1'b0, 5);
    chk("s5_press_cnt", t_press, 1);
    chk("s5_long_cnt", t_long, 1);
    chk("s5_rel_cnt", t_rel, 0);

    // 6: very long hold
    clr_tally();
    run(1'b1, 40);
    run(1'b0, 6);
    chk("s6_long_cnt", t_long, 1);
`ifndef KEY_REPEAT_EN
    chk("s6_rep_cnt", t_rep, 0);
`endif

    // random key traffic with occasional resets
    for (int i = 0; i < 120; i++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 3 * LC));
      for (int j = 0; j < len; j++)
        step(lvl, ($urandom_range(0, 80) == 0) ? 1'b0 : 1'b1);
    end
    run(1'b0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
